fx3_slfifo_writer: RTL and testbench

- Transmit-side master for the FX3 synchronous slave-FIFO interface. Moves words from an upstream ready/valid source into the FX3 write socket (FPGA->USB).
- Generates the SLCS, SLWR and PKTEND strobes and the address lines, and throttles on the FX3 full and watermark flags.
- Sits beside the existing slave-FIFO reader on the shared GPIF bus. DATA_DIR selects which block owns the bus.

---
 rtl/fx3_pkg.sv | 19 +
 rtl/fx3_slfifo_writer.sv | 151 +++++++++++++++
 tb/tb_fx3_slfifo_writer.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fx3_pkg.sv
// Shared FX3 slave-FIFO definitions: state encoding,
// socket addresses and strobe levels for reader and writer.
package fx3_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SETUP    = 4'd1,
    ST_WAIT_RDY = 4'd2,
    ST_WRITE    = 4'd3,
    ST_PKTEND   = 4'd4,
    ST_GAP      = 4'd5
  } fx3_state_t;

  localparam logic [1:0] FX3_ADDR_WR   = 2'b00;
  localparam logic [1:0] FX3_ADDR_IDLE = 2'b11;
  localparam logic       STROBE_OFF    = 1'b1;
  localparam logic       STROBE_ON     = 1'b0;

endpackage

// File: rtl/fx3_slfifo_writer.sv
// FX3 synchronous slave-FIFO write master: moves words from a
// ready/valid source into the FX3 write socket.
module fx3_slfifo_writer
  import fx3_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 256,
  parameter int SETUP_CYC = 3,
  parameter int GAP_CYC   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              DATA_DIR,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic              pkt_flush,
  input  logic              FLAGA,
  input  logic              FLAGB,
  output logic              SLCS,
  output logic              SLWR,
  output logic              SLOE,
  output logic              SLRD,
  output logic              PKTEND,
  output logic [1:0]        A,
  output logic [DATA_W-1:0] DQ,
  output logic              DQ_oe,
  output logic [8:0]        wr_cnt,
  output logic [3:0]        wr_state
);

  fx3_state_t state;
  logic       fa_q;
  logic       fb_q;
  logic       flush_pend;
  logic [7:0] tmr;
  logic       hs;
  logic [8:0] cnt_nxt;

  assign src_ready = DATA_DIR
                   && (state == ST_WRITE)
                   && fb_q
                   && (wr_cnt < 9'(BURST_MAX));
  assign hs        = src_valid && src_ready;
  assign cnt_nxt   = hs ? wr_cnt + 9'd1 : wr_cnt;
  assign SLOE      = STROBE_OFF;
  assign SLRD      = STROBE_OFF;
  assign wr_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      fa_q       <= 1'b0;
      fb_q       <= 1'b0;
      flush_pend <= 1'b0;
      tmr        <= '0;
      wr_cnt     <= '0;
      SLCS       <= STROBE_OFF;
      SLWR       <= STROBE_OFF;
      PKTEND     <= STROBE_OFF;
      A          <= FX3_ADDR_IDLE;
      DQ         <= '0;
      DQ_oe      <= 1'b0;
    end else begin
      fa_q   <= FLAGA;
      fb_q   <= FLAGB;
      SLWR   <= STROBE_OFF;
      PKTEND <= STROBE_OFF;
      if (pkt_flush) flush_pend <= 1'b1;
      if (!DATA_DIR) begin
        // a word already on the pins finishes; nothing new starts
        state      <= ST_IDLE;
        flush_pend <= 1'b0;
        wr_cnt     <= '0;
        tmr        <= '0;
        SLCS       <= STROBE_OFF;
        A          <= FX3_ADDR_IDLE;
        DQ_oe      <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            wr_cnt <= '0;
            SLCS   <= STROBE_OFF;
            A      <= FX3_ADDR_IDLE;
            DQ_oe  <= 1'b0;
            if (src_valid || flush_pend) begin
              SLCS  <= STROBE_ON;
              A     <= FX3_ADDR_WR;
              tmr   <= '0;
              state <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            if (tmr == 8'(SETUP_CYC - 1)) state <= ST_WAIT_RDY;
            else tmr <= tmr + 8'd1;
          end
          ST_WAIT_RDY: begin
            if (fa_q) begin
              DQ_oe <= 1'b1;
              state <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            if (hs) begin
              SLWR   <= STROBE_ON;
              DQ     <= src_data;
              wr_cnt <= cnt_nxt;
            end
            if (!fb_q || cnt_nxt == 9'(BURST_MAX)) begin
              tmr   <= '0;
              state <= ST_GAP;
            end else if (flush_pend && !hs) begin
              if (wr_cnt != '0) begin
                PKTEND <= STROBE_ON;
                state  <= ST_PKTEND;
              end else begin
                // nothing written: drop the flush, no ZLP
                flush_pend <= pkt_flush;
                SLCS       <= STROBE_OFF;
                A          <= FX3_ADDR_IDLE;
                DQ_oe      <= 1'b0;
                state      <= ST_IDLE;
              end
            end
          end
          ST_PKTEND: begin
            flush_pend <= pkt_flush;
            SLCS       <= STROBE_OFF;
            A          <= FX3_ADDR_IDLE;
            DQ_oe      <= 1'b0;
            tmr        <= '0;
            state      <= ST_GAP;
          end
          ST_GAP: begin
            SLCS  <= STROBE_OFF;
            A     <= FX3_ADDR_IDLE;
            DQ_oe <= 1'b0;
            if (tmr == 8'(GAP_CYC - 1)) begin
              wr_cnt <= '0;
              state  <= ST_IDLE;
            end else begin
              tmr <= tmr + 8'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fx3_slfifo_writer.sv
// Bench for fx3_slfifo_writer: random streams scored against
// a word queue and pin-level protocol rules.
module tb_fx3_slfifo_writer;

  localparam int DW  = 32;
  localparam int BM  = 256;
  localparam int SC  = 3;
  localparam int GC  = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          DATA_DIR = 1'b1;
  logic [DW-1:0] src_data = '0;
  logic          src_valid = 1'b0;
  logic          pkt_flush = 1'b0;
  logic          FLAGA = 1'b1;
  logic          FLAGB = 1'b1;
  logic          src_ready;
  logic          SLCS, SLWR, SLOE, SLRD, PKTEND;
  logic [1:0]    A;
  logic [DW-1:0] DQ;
  logic          DQ_oe;
  logic [8:0]    wr_cnt;
  logic [3:0]    wr_state;

  fx3_slfifo_writer #(
    .DATA_W(DW), .BURST_MAX(BM),
    .SETUP_CYC(SC), .GAP_CYC(GC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .DATA_DIR(DATA_DIR),
    .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .pkt_flush(pkt_flush),
    .FLAGA(FLAGA), .FLAGB(FLAGB),
    .SLCS(SLCS), .SLWR(SLWR), .SLOE(SLOE), .SLRD(SLRD),
    .PKTEND(PKTEND), .A(A), .DQ(DQ), .DQ_oe(DQ_oe),
    .wr_cnt(wr_cnt), .wr_state(wr_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc, hs_cnt, slwr_cnt, run, max_run;
  int last_wr_cyc, pkt_cnt, pkt_cyc, gap_cnt;
  int sb_bad, proto_bad;
  logic [DW-1:0] exp_q[$];

  task automatic clr();
    cyc = 0; hs_cnt = 0; slwr_cnt = 0; run = 0;
    max_run = 0; last_wr_cyc = -1; pkt_cnt = 0;
    pkt_cyc = -1; gap_cnt = 0; sb_bad = 0;
    proto_bad = 0;
    exp_q.delete();
  endtask

  // one clock: log the handshake, then observe the pins
  task automatic step();
    logic [DW-1:0] w;
    #1;
    if (rst_n && src_valid && src_ready) begin
      exp_q.push_back(src_data);
      hs_cnt++;
    end
    @(negedge clk);
    cyc++;
    if (SLWR === 1'b0) begin
      slwr_cnt++; run++;
      if (run > max_run) max_run = run;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) sb_bad++;
      else begin
        w = exp_q.pop_front();
        if (DQ !== w) sb_bad++;
      end
      if (SLCS !== 1'b0 || DQ_oe !== 1'b1
          || PKTEND !== 1'b1) proto_bad++;
    end else run = 0;
    if (PKTEND === 1'b0) begin
      pkt_cnt++; pkt_cyc = cyc;
      if (SLWR !== 1'b1 || SLCS !== 1'b0) proto_bad++;
    end
    if (wr_state === 4'd5) gap_cnt++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({SLCS, SLWR, SLOE, SLRD, PKTEND} !== 5'b11111) begin
      errors++;
      $display("FAIL rst_strobes got %b exp 11111",
        {SLCS, SLWR, SLOE, SLRD, PKTEND});
    end
    checks++;
    if (A !== 2'b11 || DQ_oe !== 1'b0 || DQ !== '0) begin
      errors++;
      $display("FAIL rst_bus got A=%b oe=%b dq=%h exp 11 0 0",
        A, DQ_oe, DQ);
    end
    checks++;
    if (wr_cnt !== 9'd0 || wr_state !== 4'd0) begin
      errors++;
      $display("FAIL rst_cnt got %0d/%0d exp 0/0",
        wr_cnt, wr_state);
    end
    checks++;
    if (src_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready got %b exp 0", src_ready);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_burst();
    int g = 0;
    int slcs_c = -1;
    int rdy_c = -1;
    int at_gap = -1;
    bit seen_gap = 0;
    clr();
    src_valid = 1'b1;
    while (!(seen_gap && wr_state == 4'd0) && g < 2000) begin
      if (hs_cnt >= BM) src_valid = 1'b0;
      else src_data = DW'(hs_cnt);
      step(); g++;
      if (SLCS === 1'b0 && slcs_c < 0) slcs_c = cyc;
      if (src_ready === 1'b1 && rdy_c < 0) rdy_c = cyc;
      if (wr_state === 4'd5 && !seen_gap) begin
        seen_gap = 1; at_gap = int'(wr_cnt);
      end
    end
    src_valid = 1'b0;
    checks++;
    if (g >= 2000) begin
      errors++;
      $display("FAIL burst_timeout got %0d exp <2000", g);
    end
    checks++;
    if (rdy_c - slcs_c !== SC + 1) begin
      errors++;
      $display("FAIL burst_setup got %0d exp %0d",
        rdy_c - slcs_c, SC + 1);
    end
    checks++;
    if (slwr_cnt !== BM || max_run !== BM) begin
      errors++;
      $display("FAIL burst_words got %0d run %0d exp %0d",
        slwr_cnt, max_run, BM);
    end
    checks++;
    if (sb_bad !== 0 || proto_bad !== 0) begin
      errors++;
      $display("FAIL burst_data got bad %0d/%0d exp 0/0",
        sb_bad, proto_bad);
    end
    checks++;
    if (at_gap !== BM) begin
      errors++;
      $display("FAIL burst_wrcnt got %0d exp %0d", at_gap, BM);
    end
    checks++;
    if (gap_cnt !== GC) begin
      errors++;
      $display("FAIL burst_gap got %0d exp %0d", gap_cnt, GC);
    end
  endtask

  task automatic test_short_packet(input int n);
    int g = 0;
    int at_flush = -1;
    int st_wait = -1;
    int wr_wait = -1;
    bit flushed = 0;
    clr();
    FLAGA = 1'b0;
    while (!(flushed && pkt_cnt > 0 && wr_state == 4'd0)
           && g < 3000) begin
      pkt_flush = 1'b0;
      if (hs_cnt < n) begin
        src_valid = (cyc == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        src_data  = $urandom;
      end else begin
        src_valid = 1'b0;
        if (!flushed) begin
          flushed = 1; pkt_flush = 1'b1;
          at_flush = int'(wr_cnt);
        end
      end
      step(); g++;
      if (cyc == 12) begin
        st_wait = int'(wr_state); wr_wait = slwr_cnt;
        FLAGA = 1'b1;
      end
    end
    pkt_flush = 1'b0;
    checks++;
    if (g >= 3000) begin
      errors++;
      $display("FAIL short_timeout n=%0d got %0d exp <3000", n, g);
    end
    checks++;
    if (st_wait !== 2 || wr_wait !== 0) begin
      errors++;
      $display("FAIL short_waitrdy got st %0d wr %0d exp 2 0",
        st_wait, wr_wait);
    end
    checks++;
    if (at_flush !== n) begin
      errors++;
      $display("FAIL short_wrcnt got %0d exp %0d", at_flush, n);
    end
    checks++;
    if (slwr_cnt !== n || sb_bad !== 0) begin
      errors++;
      $display("FAIL short_words got %0d bad %0d exp %0d 0",
        slwr_cnt, sb_bad, n);
    end
    checks++;
    if (pkt_cnt !== 1 || proto_bad !== 0) begin
      errors++;
      $display("FAIL short_pktend got %0d proto %0d exp 1 0",
        pkt_cnt, proto_bad);
    end
  endtask

  task automatic test_flush_same_cycle();
    int g = 0;
    int n;
    bit flushed = 0;
    n = $urandom_range(5, 50);
    clr();
    while (!(flushed && pkt_cnt > 0 && wr_state == 4'd0)
           && g < 2000) begin
      pkt_flush = 1'b0;
      src_data  = $urandom;
      if (hs_cnt < n - 1) src_valid = 1'b1;
      else if (!flushed && src_ready === 1'b1) begin
        src_valid = 1'b1; pkt_flush = 1'b1; flushed = 1;
      end else if (flushed) src_valid = 1'b0;
      step(); g++;
    end
    pkt_flush = 1'b0; src_valid = 1'b0;
    checks++;
    if (g >= 2000 || slwr_cnt !== n || sb_bad !== 0) begin
      errors++;
      $display("FAIL same_words got %0d bad %0d g %0d exp %0d",
        slwr_cnt, sb_bad, g, n);
    end
    checks++;
    if (pkt_cnt !== 1 || proto_bad !== 0) begin
      errors++;
      $display("FAIL same_pktend got %0d proto %0d exp 1 0",
        pkt_cnt, proto_bad);
    end
    checks++;
    if (pkt_cyc !== last_wr_cyc + 1) begin
      errors++;
      $display("FAIL same_order got %0d exp %0d",
        pkt_cyc, last_wr_cyc + 1);
    end
  endtask

  task automatic test_zlp();
    int late = 0;
    clr();
    src_valid = 1'b0;
    pkt_flush = 1'b1;
    step();
    pkt_flush = 1'b0;
    repeat (20) step();
    repeat (10) begin
      step();
      if (wr_state !== 4'd0 || SLCS !== 1'b1) late++;
    end
    checks++;
    if (pkt_cnt !== 0 || slwr_cnt !== 0) begin
      errors++;
      $display("FAIL zlp_strobes got pkt %0d wr %0d exp 0 0",
        pkt_cnt, slwr_cnt);
    end
    checks++;
    if (late !== 0) begin
      errors++;
      $display("FAIL zlp_idle got %0d busy cycles exp 0", late);
    end
  endtask

  task automatic test_watermark();
    int g = 0;
    int drop_c = -1;
    int rdy_after = -1;
    bit seen_gap = 0;
    clr();
    src_valid = 1'b1;
    while (!(seen_gap && wr_state == 4'd0) && g < 2000) begin
      src_data = $urandom;
      step(); g++;
      if (hs_cnt == 40 && drop_c < 0) begin
        FLAGB = 1'b0; drop_c = cyc;
      end
      if (drop_c >= 0 && cyc == drop_c + 1)
        rdy_after = int'(src_ready);
      if (wr_state === 4'd5) seen_gap = 1;
      if (seen_gap) src_valid = 1'b0;
    end
    src_valid = 1'b0;
    FLAGB = 1'b1;
    checks++;
    if (g >= 2000 || !seen_gap) begin
      errors++;
      $display("FAIL wm_gap got g %0d gap %0d exp <2000 1",
        g, seen_gap);
    end
    checks++;
    if (rdy_after !== 0) begin
      errors++;
      $display("FAIL wm_ready got %0d exp 0", rdy_after);
    end
    checks++;
    if (slwr_cnt !== 41 || sb_bad !== 0 || proto_bad !== 0) begin
      errors++;
      $display("FAIL wm_words got %0d bad %0d/%0d exp 41 0/0",
        slwr_cnt, sb_bad, proto_bad);
    end
    repeat (3) step();
  endtask

  task automatic test_dir_change();
    int g = 0;
    clr();
    src_valid = 1'b1;
    while (hs_cnt < 17 && g < 1000) begin
      src_data = $urandom;
      step(); g++;
    end
    DATA_DIR = 1'b0;
    step();
    checks++;
    if (wr_state !== 4'd0 || DQ_oe !== 1'b0 || A !== 2'b11) begin
      errors++;
      $display("FAIL dir_idle got st %0d oe %b A %b exp 0 0 11",
        wr_state, DQ_oe, A);
    end
    checks++;
    if (wr_cnt !== 9'd0) begin
      errors++;
      $display("FAIL dir_wrcnt got %0d exp 0", wr_cnt);
    end
    repeat (9) step();
    checks++;
    if (g >= 1000 || slwr_cnt !== 17 || src_ready !== 1'b0) begin
      errors++;
      $display("FAIL dir_words got %0d rdy %b exp 17 0",
        slwr_cnt, src_ready);
    end
    DATA_DIR = 1'b1;
    src_valid = 1'b0;
    repeat (3) step();
    checks++;
    if (wr_state !== 4'd0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL dir_after got st %0d q %0d exp 0 0",
        wr_state, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int g = 0;
    clr();
    src_valid = 1'b1;
    while (hs_cnt < 100 && g < 1000) begin
      src_data = $urandom;
      step(); g++;
    end
    checks++;
    if (wr_cnt !== 9'd100) begin
      errors++;
      $display("FAIL mid_wrcnt got %0d exp 100", wr_cnt);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({SLCS, SLWR, PKTEND} !== 3'b111 || A !== 2'b11) begin
      errors++;
      $display("FAIL mid_strobes got %b A %b exp 111 11",
        {SLCS, SLWR, PKTEND}, A);
    end
    checks++;
    if (DQ_oe !== 1'b0 || DQ !== '0 || wr_cnt !== 9'd0
        || wr_state !== 4'd0 || src_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_regs got oe %b cnt %0d st %0d exp 0 0 0",
        DQ_oe, wr_cnt, wr_state);
    end
    src_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_short_packet(10);
    test_short_packet($urandom_range(11, 200));
    test_short_packet($urandom_range(11, 200));
    test_flush_same_cycle();
    test_zlp();
    test_watermark();
    test_dir_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
